// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

    typedef logic [31:0] instruction_type;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } fetch_state_t;

    // addi x0, x0, 0
    localparam instruction_type DEFAULT_NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        instruction_type instr;
        logic [31:0]     pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instruction, pc} holding register that catches a response
// arriving while decode is stalled.
module fetch_skid_buffer
    import fetch_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic         full,
    output fetch_entry_t entry
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            full <= 1'b0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

    // NOTE: the payload is deliberately not reset; it is only observed while full is set.
    always_ff @(posedge clk) begin
        if (push) begin
            entry <= push_entry;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC ownership, single-outstanding program-memory requests
// and the IF/ID register. Define FETCH_PERF_EN to add the perf_* counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0]     RESET_PC  = 32'h0000_0000,
    parameter instruction_type NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCWrite,
    input  logic            FetchWrite,
    input  logic            PCSrc,
    input  logic [31:0]     pc_branch,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output instruction_type instruction,
    output logic [31:0]     pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_killed,
    output logic [31:0]     perf_stall,
`endif
    output logic            fetch_valid
);

    fetch_state_t state;
    logic [31:0]  pc_q;
    logic [31:0]  req_pc;
    logic [31:0]  redir_pc;
    logic         kill;

    logic         skid_full;
    fetch_entry_t skid_entry;

    logic [31:0]  branch_tgt;
    logic         rsp_here;
    logic         live;
    logic         skid_push;
    logic         skid_pop;
    logic         skid_full_next;
    logic         start_req;

    // NOTE: every signal here is a plain assignment on every path, so no latch can be inferred.
    always_comb begin
        branch_tgt     = word_align(pc_branch);
        rsp_here       = (state == S_WAIT) && imem_rvalid;
        live           = rsp_here && !kill && !PCSrc;
        skid_pop       = FetchWrite && skid_full && !PCSrc;
        skid_push      = live && !FetchWrite;
        skid_full_next = !PCSrc && ((skid_full && !skid_pop) || skid_push);
        start_req      = PCSrc || (PCWrite && !skid_full_next);
    end

    // Gating with rst keeps the request low throughout the reset cycle.
    assign imem_req  = rst && (state == S_REQ);
    assign imem_addr = pc_q;

    fetch_skid_buffer u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (skid_push),
        .pop        (skid_pop),
        .flush      (PCSrc),
        .push_entry ('{instr: imem_rdata, pc: req_pc}),
        .full       (skid_full),
        .entry      (skid_entry)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc   <= RESET_PC;
            redir_pc <= RESET_PC;
            kill     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (PCSrc) pc_q <= branch_tgt;
                    if (start_req) state <= S_REQ;
                end
                S_REQ: begin
                    // Address stays stable until granted; a redirect seen here is parked in redir_pc.
                    if (imem_gnt) begin
                        req_pc <= pc_q;
                        state  <= S_WAIT;
                        if (PCSrc) begin
                            pc_q <= branch_tgt;
                            kill <= 1'b1;
                        end else if (kill) begin
                            pc_q <= redir_pc;
                        end else begin
                            pc_q <= pc_q + 32'd4;
                        end
                    end else if (PCSrc) begin
                        redir_pc <= branch_tgt;
                        kill     <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (PCSrc) pc_q <= branch_tgt;
                    if (imem_rvalid) begin
                        kill  <= 1'b0;
                        state <= start_req ? S_REQ : S_IDLE;
                    end else if (PCSrc) begin
                        kill <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // IF/ID register: redirect bubble, then skid entry, then live response, else bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            instruction <= NOP_INSTR;
            pc          <= 32'h0;
            fetch_valid <= 1'b0;
        end else if (PCSrc) begin
            instruction <= NOP_INSTR;
            fetch_valid <= 1'b0;
        end else if (FetchWrite) begin
            if (skid_full) begin
                instruction <= skid_entry.instr;
                pc          <= skid_entry.pc;
                fetch_valid <= 1'b1;
            end else if (live) begin
                instruction <= imem_rdata;
                pc          <= req_pc;
                fetch_valid <= 1'b1;
            end else begin
                instruction <= NOP_INSTR;
                fetch_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched <= 32'h0;
            perf_killed  <= 32'h0;
            perf_stall   <= 32'h0;
        end else begin
            if (skid_pop || (live && FetchWrite)) perf_fetched <= perf_fetched + 32'd1;
            if ((rsp_here && (kill || PCSrc)) || (PCSrc && skid_full)) perf_killed <= perf_killed + 32'd1;
            if (!FetchWrite) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; perf counters are checked
// when FETCH_PERF_EN is defined.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite, FetchWrite, PCSrc;
    logic [31:0] pc_branch;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        fetch_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_killed, perf_stall;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .PCWrite     (PCWrite),
        .FetchWrite  (FetchWrite),
        .PCSrc       (PCSrc),
        .pc_branch   (pc_branch),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .pc          (pc),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_killed (perf_killed),
        .perf_stall  (perf_stall),
`endif
        .fetch_valid (fetch_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] e_instr,
                              input logic [31:0] e_pc, input logic e_valid);
        check({tag, "_instr"}, instruction, e_instr);
        check({tag, "_pc"}, pc, e_pc);
        check({tag, "_valid"}, {31'b0, fetch_valid}, {31'b0, e_valid});
    endtask

    // Wait (bounded) for a request, check its address, grant it, answer next cycle.
    task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
        int n = 0;
        #1;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, {31'b0, imem_req}, 32'd1);
        check({tag, "_addr"}, imem_addr, exp_addr);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; PCWrite = 1'b1; FetchWrite = 1'b1; PCSrc = 1'b0;
        pc_branch = 32'h0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

        // Reset state
        tick(); tick();
        check_ifid("reset", NOP, 32'h0, 1'b0);
        check("reset_req", {31'b0, imem_req}, 32'd0);
        rst = 1'b1;

        // 1: first fetch at RESET_PC, then a bubble, next address 0x4
        serve("t1", 32'h0, 32'h0050_0093);
        check_ifid("t1_out", 32'h0050_0093, 32'h0, 1'b1);
        check("t1_next_addr", imem_addr, 32'h4);
        tick();
        check_ifid("t1_bubble", NOP, 32'h0, 1'b0);

        // 2: decode stalls for 3 cycles while word at 0x8 returns
        serve("t2a", 32'h4, 32'h00A0_0113);
        check_ifid("t2a_out", 32'h00A0_0113, 32'h4, 1'b1);
        FetchWrite = 1'b0;
        serve("t2b", 32'h8, 32'h0020_8193);
        check_ifid("t2_hold", 32'h00A0_0113, 32'h4, 1'b1);
        check("t2_req_low", {31'b0, imem_req}, 32'd0);
        tick();
        check("t2_req_low2", {31'b0, imem_req}, 32'd0);
        check_ifid("t2_hold2", 32'h00A0_0113, 32'h4, 1'b1);
        FetchWrite = 1'b1;
        tick();
        check_ifid("t2_skid_out", 32'h0020_8193, 32'h8, 1'b1);
        serve("t2c", 32'hC, 32'h0030_0213);
        check_ifid("t2c_out", 32'h0030_0213, 32'hC, 1'b1);

        // 3: redirect while waiting on 0x10
        #1;
        check("t3_addr", imem_addr, 32'h10);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        PCSrc = 1'b1; pc_branch = 32'h40;
        tick();
        PCSrc = 1'b0;
        check_ifid("t3_bubble", NOP, 32'hC, 1'b0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("t3_dropped", {31'b0, fetch_valid}, 32'd0);
        serve("t3b", 32'h40, 32'h0040_0293);
        check_ifid("t3b_out", 32'h0040_0293, 32'h40, 1'b1);

        // 4: redirect coincident with rvalid; unaligned target forced to 0x80
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0044;
        PCSrc = 1'b1; pc_branch = 32'h83;
        tick();
        imem_rvalid = 1'b0; PCSrc = 1'b0;
        check_ifid("t4_bubble", NOP, 32'h40, 1'b0);
        serve("t4b", 32'h80, 32'h0050_0313);
        check_ifid("t4b_out", 32'h0050_0313, 32'h80, 1'b1);

        // Redirect in S_REQ without grant: old address completes and is dropped
        PCSrc = 1'b1; pc_branch = 32'h100;
        tick();
        PCSrc = 1'b0;
        check("sreq_addr_held", imem_addr, 32'h84);
        check("sreq_req_held", {31'b0, imem_req}, 32'd1);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0084;
        tick();
        imem_rvalid = 1'b0;
        check("sreq_dropped", {31'b0, fetch_valid}, 32'd0);
        check("sreq_new_addr", imem_addr, 32'h100);

        // 5: reset during S_WAIT; a stale response afterwards is ignored
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst = 1'b0;
        tick();
        check_ifid("t5_reset", NOP, 32'h0, 1'b0);
        check("t5_req", {31'b0, imem_req}, 32'd0);
        rst = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0100;
        tick();
        imem_rvalid = 1'b0;
        check("t5_stale_valid", {31'b0, fetch_valid}, 32'd0);
        check("t5_addr", imem_addr, 32'h0);

        // 6: two delivered, one killed, three stall cycles
        serve("t6a", 32'h0, 32'h1111_1111);
        check_ifid("t6a_out", 32'h1111_1111, 32'h0, 1'b1);
        serve("t6b", 32'h4, 32'h2222_2222);
        check_ifid("t6b_out", 32'h2222_2222, 32'h4, 1'b1);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
        PCSrc = 1'b1; pc_branch = 32'h200;
        tick();
        imem_rvalid = 1'b0; PCSrc = 1'b0;
        FetchWrite = 1'b0;
        tick(); tick(); tick();
        FetchWrite = 1'b1;
        check("t6_addr", imem_addr, 32'h200);
`ifdef FETCH_PERF_EN
        check("t6_perf_fetched", perf_fetched, 32'd2);
        check("t6_perf_killed", perf_killed, 32'd1);
        check("t6_perf_stall", perf_stall, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
